// File: rtl/nios2_jtag_scan_pkg.sv
// nios2_jtag_scan_pkg: shared state encoding and default widths for the JTAG scan master
package nios2_jtag_scan_pkg;
    localparam int SR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;
    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} scan_state_e;
endpackage

// File: rtl/nios2_nios2_qsys_jtag_scan_tckgen.sv
// nios2_nios2_qsys_jtag_scan_tckgen: TCK generator; low half then high half of each period while en
// Ports: clk, reset_n (async active-low), en in; tck, tck_rise, period_start, period_end out.
module nios2_nios2_qsys_jtag_scan_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic period_start,
    output logic period_end
);
    localparam int CW = $clog2(2 * TCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TCK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (!en || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign tck          = cnt_q >= HALF;
    assign tck_rise     = cnt_q == HALF;
    assign period_start = cnt_q == '0;
    assign period_end   = cnt_q == LAST;
endmodule

// File: rtl/nios2_nios2_qsys_jtag_scan_master.sv
// nios2_nios2_qsys_jtag_scan_master: issues one IR load plus one DR scan per command over virtual JTAG
// Ports: clk, reset_n (async active-low); cmd_valid/cmd_ready/cmd_ir/cmd_data command in;
// rsp_valid/rsp_data response out; busy; vji_tck/tdi/ir_in/uir/cdr/sdr/udr/rti out, vji_tdo in.
// Option: define NIOS2_JTAG_SCAN_IR_CACHE_EN to skip UIR when the IR is unchanged.
module nios2_nios2_qsys_jtag_scan_master
    import nios2_jtag_scan_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int SR_WIDTH = SR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int BW = $clog2(SR_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(SR_WIDTH - 1);
    scan_state_e state_q, state_d;
    logic [SR_WIDTH-1:0] data_q, data_d, sh_q, sh_d, rsp_q, rsp_d;
    logic [IR_WIDTH-1:0] ir_lat_q, ir_lat_d, ir_out_q, ir_out_d;
    logic [BW-1:0] bit_q, bit_d;
    logic accept, skip_uir, tck_rise, period_start, period_end;
    assign cmd_ready = state_q == IDLE || state_q == DONE;
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    nios2_nios2_qsys_jtag_scan_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (busy),
        .tck          (vji_tck),
        .tck_rise     (tck_rise),
        .period_start (period_start),
        .period_end   (period_end)
    );
`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
    // ir_out_q doubles as the cached last IR; valid only once a UIR has completed since reset
    logic irv_q, irv_d;
    assign skip_uir = irv_q && cmd_ir == ir_out_q;
    always_comb irv_d = irv_q || (state_q == UIR && period_end);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) irv_q <= 1'b0;
        else irv_q <= irv_d;
`else
    assign skip_uir = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sh_d     = sh_q;
        rsp_d    = rsp_q;
        ir_lat_d = ir_lat_q;
        ir_out_d = ir_out_q;
        bit_d    = bit_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = accept ? (skip_uir ? CDR : UIR) : IDLE;
                if (accept) begin
                    data_d   = cmd_data;
                    ir_lat_d = cmd_ir;
                end
            end
            UIR: begin
                if (period_start) ir_out_d = ir_lat_q;
                if (period_end) state_d = CDR;
            end
            CDR: if (period_end) state_d = SDR;
            SDR: begin
                if (tck_rise) sh_d = {vji_tdo, sh_q[SR_WIDTH-1:1]};
                if (period_end) begin
                    bit_d   = bit_q == LAST_BIT ? '0 : bit_q + 1'b1;
                    state_d = bit_q == LAST_BIT ? UDR : SDR;
                end
            end
            UDR: if (period_end) state_d = RTI;
            RTI: begin
                if (period_end) begin
                    state_d = DONE;
                    rsp_d   = sh_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            sh_q     <= '0;
            rsp_q    <= '0;
            ir_lat_q <= '0;
            ir_out_q <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sh_q     <= sh_d;
            rsp_q    <= rsp_d;
            ir_lat_q <= ir_lat_d;
            ir_out_q <= ir_out_d;
            bit_q    <= bit_d;
        end
    // During UIR the freshly latched IR is shown combinationally so it is valid from the first cycle
    assign vji_ir_in = state_q == UIR ? ir_lat_q : ir_out_q;
    assign vji_tdi   = state_q == SDR && data_q[bit_q];
    assign vji_uir   = state_q == UIR;
    assign vji_cdr   = state_q == CDR;
    assign vji_sdr   = state_q == SDR;
    assign vji_udr   = state_q == UDR;
    assign vji_rti   = state_q == RTI;
    assign rsp_valid = state_q == DONE;
    assign rsp_data  = rsp_q;
endmodule
